axis_stream_monitor: RTL and testbench
======================================

# axis_stream_monitor

Synthesizable, multi-channel AXI-Stream protocol monitor for simulation benches and on-chip debug. It passively observes NCH independent streams and flags handshake-stability, reserved-encoding, reset, packet-length and stall violations in per-channel sticky error registers. It also keeps per-channel packet/byte statistics. It never drives TREADY or TVALID; it sits in parallel with any master/slave pair.

## Interface
- NCH, 2, number of monitored channels (1..16)
- DW, 32, TDATA width in bits (multiple of 8)
- UW, 1, TUSER width
- DESTW, 1, TDEST width
- LGDEPTH, 16, width of byte and packet counters
- MAX_PACKET, 0, max bytes per packet; 0 disables check
- MIN_PACKET, 0, min bytes per packet; 0 disables check
- MAX_STALL, 0, max consecutive TVALID&&!TREADY cycles; 0 disables check

Ports:
- i_aclk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_clear  in  NCH  per-channel sticky-error clear, one-cycle pulse
- i_tvalid, i_tready, i_tlast  in  NCH  per-channel handshake
- i_tdata  in  NCH*DW  channel c at [c*DW +: DW]
- i_tstrb, i_tkeep  in  NCH*DW/8  channel c at [c*DW/8 +: DW/8]
- i_tuser  in  NCH*UW;  i_tdest  in  NCH*DESTW
- o_err  out  NCH*7  sticky error bits, channel c at [c*7 +: 7]
- o_err_any  out  1  OR of all o_err bits, registered
- o_pkt_count  out  NCH*LGDEPTH  completed packets per channel, saturating
- o_byte_count  out  NCH*LGDEPTH  bytes in currently open packet

## Operation
- Error bits per channel: [0] VALID_DROP (TVALID fell while stalled); [1] PAYLOAD_CHG (TLAST/TSTRB/TKEEP/TUSER/TDEST, or any TDATA byte with TKEEP high, changed while stalled); [2] RESERVED (TVALID && (~TKEEP & TSTRB) != 0); [3] TOO_LONG (byte_count + vbytes > MAX_PACKET); [4] TOO_SHORT (TVALID && TLAST && byte_count + vbytes < MIN_PACKET); [5] STALL (stall counter reached MAX_STALL); [6] RST_VALID (TVALID high in the first cycle after i_reset deasserts).
- vbytes = popcount(TKEEP & TSTRB) of the current beat; 0 when !TVALID.
- "Stalled" = previous cycle had TVALID && !TREADY and i_reset low.
- Per-channel FSM: IDLE (no packet open) -> OPEN on accepted beat with !TLAST; OPEN -> IDLE on accepted beat with TLAST. Accepted = TVALID && TREADY.
- byte_count: on accepted !TLAST beat += vbytes, saturating at all-ones; on accepted TLAST beat -> 0. pkt_count += 1 on accepted TLAST, saturating.
- Stall counter: 0 when !TVALID or TREADY or reset; else increments, saturating at MAX_STALL.
- Errors are sticky until i_clear[c] or i_reset. A new error in the clear cycle wins (set has priority over clear).
- Channels are fully independent; no cross-channel state besides o_err_any.

## Timing
- Reset: all o_err, o_byte_count, o_pkt_count, o_err_any = 0; FSMs IDLE; stall counters 0; past-reset flag set.
- A violation on cycle N appears in o_err on cycle N+1; o_err_any on N+2.
- Counter outputs update on the cycle after the accepting beat.
- Reset mid-packet: byte_count and FSM return to 0/IDLE; no TOO_SHORT is raised for the aborted packet.
- Checks [0],[1] use stored previous-cycle beat (one register set per channel of all payload fields).
- TOO_LONG and TOO_SHORT may both fire on the same beat. Both bits are set.
- STALL fires once the counter reaches MAX_STALL. It stays asserted (sticky) even after TREADY rises.

## Test plan
- Ch0 TVALID=1, TREADY=0 for 3 cycles, TDATA changes 0x11223344->0x11223345 with TKEEP=0xF -> o_err[1]=1 next cycle; repeat with TKEEP=0xE -> no error.
- Ch1 TVALID drops after one stalled cycle -> o_err[7+0]=1, ch0 bits unaffected; i_clear=2'b10 -> ch1 bits 0 next cycle.
- MAX_PACKET=8, DW=32: beats of 4,4,4 bytes, last on third -> o_err[3] set on the third beat; pkt_count=1, byte_count=0.
- MIN_PACKET=6: single beat TKEEP=TSTRB=0x3, TLAST -> o_err[4]=1. A beat with TKEEP=0x0, TSTRB=0x1 -> o_err[2]=1.
- MAX_STALL=4: TVALID=1, TREADY=0 for 4 cycles -> o_err[5]=1; 3 cycles then TREADY -> no error.
- Assert i_reset mid-packet (byte_count=8), TVALID=1 on first post-reset cycle -> counters 0, o_err[6]=1, o_err_any=1 one cycle later.

Source files
------------

// File: rtl/axis_stream_monitor_if.sv
// Bundled AXI-Stream signals for NCH parallel channels. Channel c occupies the
// c-th slice of each packed vector. The monitor observes them through the monitor modport.
interface axis_stream_monitor_if #(
  parameter int NCH   = 2,
  parameter int DW    = 32,
  parameter int UW    = 1,
  parameter int DESTW = 1
);
  logic [NCH-1:0]        tvalid;
  logic [NCH-1:0]        tready;
  logic [NCH-1:0]        tlast;
  logic [NCH*DW-1:0]     tdata;
  logic [NCH*DW/8-1:0]   tstrb;
  logic [NCH*DW/8-1:0]   tkeep;
  logic [NCH*UW-1:0]     tuser;
  logic [NCH*DESTW-1:0]  tdest;

  modport master  (output tvalid, tlast, tdata, tstrb, tkeep, tuser, tdest, input tready);
  modport slave   (input tvalid, tlast, tdata, tstrb, tkeep, tuser, tdest, output tready);
  modport monitor (input tvalid, tready, tlast, tdata, tstrb, tkeep, tuser, tdest);
endinterface

// File: rtl/axis_stream_monitor.sv
// Passive multi-channel AXI-Stream protocol monitor: sticky per-channel error
// flags for handshake, encoding, length and stall violations, plus packet and byte counters.
module axis_stream_monitor #(
  parameter int NCH        = 2,
  parameter int DW         = 32,
  parameter int UW         = 1,
  parameter int DESTW      = 1,
  parameter int LGDEPTH    = 16,
  parameter int MAX_PACKET = 0,
  parameter int MIN_PACKET = 0,
  parameter int MAX_STALL  = 0
) (
  input  logic                     i_aclk,
  input  logic                     i_reset,
  input  logic [NCH-1:0]           i_clear,
  axis_stream_monitor_if.monitor   axis,
  output logic [NCH*7-1:0]         o_err,
  output logic                     o_err_any,
  output logic [NCH*LGDEPTH-1:0]   o_pkt_count,
  output logic [NCH*LGDEPTH-1:0]   o_byte_count
);
  localparam int SB   = DW / 8;
  localparam int SCW  = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [31:0] MAXP = (MAX_PACKET > 0) ? 32'(MAX_PACKET) : 32'd1;
  localparam logic [31:0] MINP = (MIN_PACKET > 0) ? 32'(MIN_PACKET) : 32'd1;
  localparam logic [31:0] MAXS = (MAX_STALL > 0) ? 32'(MAX_STALL) : 32'd1;

  typedef enum logic {S_IDLE, S_OPEN} state_t;

  function automatic logic [31:0] popcount(input logic [SB-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < SB; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  function automatic logic [LGDEPTH-1:0] sat_add(input logic [LGDEPTH-1:0] a,
                                                 input logic [31:0] b);
    logic [LGDEPTH+31:0] s;
    s = {32'd0, a} + {{LGDEPTH{1'b0}}, b};
    if (|s[LGDEPTH+31:LGDEPTH]) return '1;
    return s[LGDEPTH-1:0];
  endfunction

  // High exactly in the first cycle after reset deasserts
  logic past_reset_p1;
  always_ff @(posedge i_aclk) past_reset_p1 <= i_reset;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic             vld, rdy, last;
    logic [DW-1:0]    data;
    logic [SB-1:0]    strb, keep;
    logic [UW-1:0]    user;
    logic [DESTW-1:0] dest;

    assign vld  = axis.tvalid[c];
    assign rdy  = axis.tready[c];
    assign last = axis.tlast[c];
    assign data = axis.tdata[c*DW +: DW];
    assign strb = axis.tstrb[c*SB +: SB];
    assign keep = axis.tkeep[c*SB +: SB];
    assign user = axis.tuser[c*UW +: UW];
    assign dest = axis.tdest[c*DESTW +: DESTW];

    logic             stalled_p1, last_p1;
    logic [DW-1:0]    data_p1;
    logic [SB-1:0]    strb_p1, keep_p1;
    logic [UW-1:0]    user_p1;
    logic [DESTW-1:0] dest_p1;
    state_t           state_p1;
    logic [LGDEPTH-1:0] bytes_p1, pkts_p1;
    logic [SCW-1:0]   stall_p1;
    logic [6:0]       err_p1;

    logic [31:0] vbytes, sum;
    logic        chg;
    logic [6:0]  set;

    // Stage p0: classify the current beat against the stored previous beat
    always_comb begin
      vbytes = vld ? popcount(keep & strb) : 32'd0;
      sum    = 32'(bytes_p1) + vbytes;
      chg    = (last != last_p1) || (strb != strb_p1) || (keep != keep_p1) ||
               (user != user_p1) || (dest != dest_p1);
      for (int b = 0; b < SB; b++)
        if (keep[b] && (data[b*8 +: 8] != data_p1[b*8 +: 8])) chg = 1'b1;
      set    = '0;
      set[0] = stalled_p1 && !vld;
      set[1] = stalled_p1 && vld && chg;
      set[2] = vld && (|(~keep & strb));
      set[3] = (MAX_PACKET != 0) && vld && (sum > MAXP);
      set[4] = (MIN_PACKET != 0) && vld && last && (sum < MINP);
      set[5] = (MAX_STALL != 0) && vld && !rdy && ((32'(stall_p1) + 32'd1) >= MAXS);
      set[6] = past_reset_p1 && vld;
    end

    // Stage p1: control state, counters and sticky errors
    always_ff @(posedge i_aclk) begin
      if (i_reset) begin
        stalled_p1 <= 1'b0;
        state_p1   <= S_IDLE;
        bytes_p1   <= '0;
        pkts_p1    <= '0;
        stall_p1   <= '0;
        err_p1     <= '0;
      end else begin
        stalled_p1 <= vld && !rdy;
        err_p1     <= (i_clear[c] ? 7'd0 : err_p1) | set;
        if (!vld || rdy)                        stall_p1 <= '0;
        else if (stall_p1 != SCW'(MAX_STALL))   stall_p1 <= stall_p1 + SCW'(1);
        if (vld && rdy) begin
          if (last) begin
            bytes_p1 <= '0;
            pkts_p1  <= sat_add(pkts_p1, 32'd1);
          end else begin
            bytes_p1 <= sat_add(bytes_p1, vbytes);
          end
        end
        case (state_p1)
          S_IDLE:  if (vld && rdy && !last) state_p1 <= S_OPEN;
          S_OPEN:  if (vld && rdy && last)  state_p1 <= S_IDLE;
          default: state_p1 <= S_IDLE;
        endcase
      end
    end

    always_ff @(posedge i_aclk) begin
      last_p1 <= last;
      data_p1 <= data;
      strb_p1 <= strb;
      keep_p1 <= keep;
      user_p1 <= user;
      dest_p1 <= dest;
    end

    assign o_err[c*7 +: 7]              = err_p1;
    assign o_pkt_count[c*LGDEPTH +: LGDEPTH]  = pkts_p1;
    assign o_byte_count[c*LGDEPTH +: LGDEPTH] = bytes_p1;
  end

  // Stage p2: global summary, one cycle behind the sticky bits
  always_ff @(posedge i_aclk) begin
    if (i_reset) o_err_any <= 1'b0;
    else         o_err_any <= |o_err;
  end
endmodule

// File: tb/tb_axis_stream_monitor.sv
// Bench for axis_stream_monitor: directed steps from the test plan followed by
// randomized traffic, every cycle compared against a rule-level reference model.
module tb_axis_stream_monitor;
  localparam int NCH = 2, DW = 32, SB = 4, LGD = 16;
  localparam int MAXP = 8, MINP = 6, MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] clear = '0;
  logic [NCH*7-1:0]   o_err;
  logic               o_err_any;
  logic [NCH*LGD-1:0] o_pkt_count, o_byte_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axis_stream_monitor_if #(.NCH(NCH), .DW(DW), .UW(1), .DESTW(1)) bus ();

  axis_stream_monitor #(
    .NCH(NCH), .DW(DW), .UW(1), .DESTW(1), .LGDEPTH(LGD),
    .MAX_PACKET(MAXP), .MIN_PACKET(MINP), .MAX_STALL(MAXS)
  ) dut (
    .i_aclk(clk), .i_reset(rst), .i_clear(clear), .axis(bus),
    .o_err(o_err), .o_err_any(o_err_any),
    .o_pkt_count(o_pkt_count), .o_byte_count(o_byte_count)
  );

  // Reference model state (values the DUT outputs should hold after the edge)
  logic [6:0]  m_err [NCH];
  int unsigned m_bytes [NCH], m_pkts [NCH], m_run [NCH];
  bit          m_stalled [NCH];
  bit          m_past_rst = 1'b0;
  bit          m_any = 1'b0;
  logic [31:0] p_data [NCH];
  logic [3:0]  p_keep [NCH], p_strb [NCH];
  logic        p_last [NCH], p_user [NCH], p_dest [NCH];

  task automatic model_step();
    bit any_n;
    any_n = 1'b0;
    for (int c = 0; c < NCH; c++) any_n |= (m_err[c] != 7'd0);
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_err[c] = '0; m_bytes[c] = 0; m_pkts[c] = 0; m_run[c] = 0; m_stalled[c] = 0;
      end
      m_any = 1'b0;
      m_past_rst = 1'b1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        logic v, r, l, u, d;
        logic [31:0] data;
        logic [3:0] k, s;
        logic [6:0] set;
        int unsigned vb, nb;
        bit chg;
        v = bus.tvalid[c]; r = bus.tready[c]; l = bus.tlast[c];
        data = bus.tdata[c*32 +: 32]; k = bus.tkeep[c*4 +: 4]; s = bus.tstrb[c*4 +: 4];
        u = bus.tuser[c]; d = bus.tdest[c];
        vb = v ? $countones(k & s) : 0;
        set = '0;
        if (m_stalled[c] && !v) set[0] = 1'b1;
        if (m_stalled[c] && v) begin
          chg = (l != p_last[c]) || (k != p_keep[c]) || (s != p_strb[c]) ||
                (u != p_user[c]) || (d != p_dest[c]);
          for (int b = 0; b < 4; b++)
            if (k[b] && data[b*8 +: 8] != p_data[c][b*8 +: 8]) chg = 1'b1;
          set[1] = chg;
        end
        if (v && ((~k & s) != 4'd0)) set[2] = 1'b1;
        if (v && m_bytes[c] + vb > MAXP) set[3] = 1'b1;
        if (v && l && m_bytes[c] + vb < MINP) set[4] = 1'b1;
        m_run[c] = (v && !r) ? m_run[c] + 1 : 0;
        if (m_run[c] >= MAXS) set[5] = 1'b1;
        if (m_past_rst && v) set[6] = 1'b1;
        m_err[c] = (clear[c] ? 7'd0 : m_err[c]) | set;
        if (v && r) begin
          if (l) begin
            m_bytes[c] = 0;
            if (m_pkts[c] < 65535) m_pkts[c] = m_pkts[c] + 1;
          end else begin
            nb = m_bytes[c] + vb;
            m_bytes[c] = (nb > 65535) ? 65535 : nb;
          end
        end
        m_stalled[c] = v && !r;
        p_data[c] = data; p_keep[c] = k; p_strb[c] = s; p_last[c] = l;
        p_user[c] = u; p_dest[c] = d;
      end
      m_any = any_n;
      m_past_rst = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NCH*7-1:0]   e_err;
    logic [NCH*LGD-1:0] e_pkt, e_byte;
    for (int c = 0; c < NCH; c++) begin
      e_err[c*7 +: 7]    = m_err[c];
      e_pkt[c*LGD +: LGD]  = 16'(m_pkts[c]);
      e_byte[c*LGD +: LGD] = 16'(m_bytes[c]);
    end
    chk("err",     64'(o_err),        64'(e_err));
    chk("err_any", 64'(o_err_any),    64'(m_any));
    chk("pkt",     64'(o_pkt_count),  64'(e_pkt));
    chk("bytes",   64'(o_byte_count), 64'(e_byte));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input int c, input bit v, input bit r, input bit l,
                       input logic [31:0] d, input logic [3:0] k, input logic [3:0] s);
    bus.tvalid[c] = v; bus.tready[c] = r; bus.tlast[c] = l;
    bus.tdata[c*32 +: 32] = d; bus.tkeep[c*4 +: 4] = k; bus.tstrb[c*4 +: 4] = s;
  endtask

  task automatic pulse_clear(input logic [NCH-1:0] m);
    clear = m; tick(); clear = '0;
  endtask

  initial begin
    logic [3:0] k, s;
    bus.tvalid = '0; bus.tready = '0; bus.tlast = '0; bus.tdata = '0;
    bus.tkeep = '0; bus.tstrb = '0; bus.tuser = '0; bus.tdest = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Payload change while stalled, then the same change on a masked byte
    drive(0, 1, 0, 0, 32'h11223344, 4'hF, 4'hF); tick();
    drive(0, 1, 0, 0, 32'h11223345, 4'hF, 4'hF); tick();
    chk("A_chg_kept", 64'(o_err[1]), 64'd1);
    tick();
    bus.tready[0] = 1'b1; tick();
    drive(0, 0, 0, 0, 32'h0, 4'h0, 4'h0); tick();
    chk("A_bytes", 64'(o_byte_count[15:0]), 64'd4);
    pulse_clear(2'b01);
    chk("A_cleared", 64'(o_err[6:0]), 64'd0);
    drive(0, 1, 0, 0, 32'h11223344, 4'hE, 4'hE); tick();
    drive(0, 1, 0, 0, 32'h11223345, 4'hE, 4'hE); tick();
    tick();
    chk("A_chg_masked", 64'(o_err[1]), 64'd0);
    bus.tready[0] = 1'b1; tick();
    drive(0, 0, 0, 0, 32'h0, 4'h0, 4'h0); tick();

    // Valid dropped while stalled on ch1 only, then a ch1 clear
    drive(1, 1, 0, 0, 32'hCAFEF00D, 4'hF, 4'hF); tick();
    drive(1, 0, 0, 0, 32'h0, 4'h0, 4'h0); tick();
    chk("B_drop_ch1", 64'(o_err[13:7]), 64'd1);
    chk("B_ch0_clean", 64'(o_err[6:0]), 64'd0);
    pulse_clear(2'b10);
    chk("B_clear_ch1", 64'(o_err[13:7]), 64'd0);

    // Close the open 7-byte packet exactly at the limit, then an overlong one
    drive(0, 1, 1, 1, 32'h5A, 4'h1, 4'h1); tick();
    chk("C_at_limit", 64'(o_err[3]), 64'd0);
    drive(0, 1, 1, 0, 32'h01010101, 4'hF, 4'hF); tick();
    drive(0, 1, 1, 0, 32'h02020202, 4'hF, 4'hF); tick();
    drive(0, 1, 1, 1, 32'h03030303, 4'hF, 4'hF); tick();
    chk("C_too_long", 64'(o_err[3]), 64'd1);
    chk("C_pkts", 64'(o_pkt_count[15:0]), 64'd2);
    chk("C_bytes", 64'(o_byte_count[15:0]), 64'd0);
    drive(0, 0, 0, 0, 32'h0, 4'h0, 4'h0);
    pulse_clear(2'b01);

    // Short packet, then a reserved TKEEP/TSTRB combination
    drive(0, 1, 1, 1, 32'hAAAA, 4'h3, 4'h3); tick();
    chk("D_too_short", 64'(o_err[4]), 64'd1);
    drive(0, 1, 1, 1, 32'h0, 4'h0, 4'h1); tick();
    chk("D_reserved", 64'(o_err[2]), 64'd1);
    drive(0, 0, 0, 0, 32'h0, 4'h0, 4'h0);
    pulse_clear(2'b01);

    // Stall of exactly MAX_STALL cycles, then one cycle short of it
    drive(0, 1, 0, 0, 32'h77, 4'hF, 4'hF);
    for (int i = 0; i < 4; i++) tick();
    chk("E_stall", 64'(o_err[5]), 64'd1);
    bus.tready[0] = 1'b1; tick();
    drive(0, 0, 0, 0, 32'h0, 4'h0, 4'h0); tick();
    pulse_clear(2'b01);
    drive(0, 1, 0, 0, 32'h88, 4'hF, 4'hF);
    for (int i = 0; i < 3; i++) tick();
    bus.tready[0] = 1'b1; tick();
    chk("E_no_stall", 64'(o_err[5]), 64'd0);
    chk("E_bytes", 64'(o_byte_count[15:0]), 64'd8);

    // Reset mid-packet with TVALID high right after reset
    drive(0, 1, 0, 0, 32'h99, 4'hF, 4'hF);
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("F_rst_valid", 64'(o_err[6]), 64'd1);
    chk("F_bytes", 64'(o_byte_count[15:0]), 64'd0);
    chk("F_pkts", 64'(o_pkt_count[15:0]), 64'd0);
    chk("F_short_none", 64'(o_err[4]), 64'd0);
    tick();
    chk("F_err_any", 64'(o_err_any), 64'd1);
    drive(0, 0, 0, 0, 32'h0, 4'h0, 4'h0); tick();

    // Randomized traffic, mostly well-behaved with occasional violations
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCH; c++) begin
        clear[c] = ($urandom_range(0, 15) == 0);
        if (m_stalled[c] && $urandom_range(0, 9) != 0) begin
          bus.tready[c] = ($urandom_range(0, 2) != 0);
        end else begin
          case ($urandom_range(0, 5))
            0, 1, 2: k = 4'hF;
            3:       k = 4'h3;
            4:       k = 4'h1;
            default: k = 4'hE;
          endcase
          s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : k;
          drive(c, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 3) == 0, $urandom, k, s);
          bus.tuser[c] = 1'($urandom);
          bus.tdest[c] = 1'($urandom);
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
